// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry-out and signed overflow.
module alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   full;
  logic             c_msb;

  assign bx    = b ^ {WIDTH{sub}};
  assign full  = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  // Carry into the MSB recovered from the MSB sum bit and its two inputs.
  assign c_msb = full[WIDTH-1] ^ a[WIDTH-1] ^ bx[WIDTH-1];
  assign sum   = full[WIDTH-1:0];
  assign cout  = full[WIDTH];
  assign ovf   = c_msb ^ full[WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic, iterative shifts and shift-add multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output state_t           state_dbg
);

  localparam int SW = $clog2(WIDTH);

  // Handshake: start is accepted on any rising edge where busy=0 (state IDLE);
  // op/a/b are captured then. done is a one-cycle pulse marking the first cycle
  // the new result/flags are valid; starts seen while busy=1 are dropped.

  state_t           state;
  logic [2:0]       op_r;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sh, mcand, mplier, acc;

  logic [WIDTH-1:0] as_a, as_b, as_sum;
  logic             as_sub, as_cout, as_ovf;

  logic [SW-1:0]    shamt;
  logic             is_shift;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_o;

  logic [WIDTH-1:0] sh_step, acc_step, mpl_step;
  logic             sh_out;

  assign shamt     = b[SW-1:0];
  assign is_shift  = (op == OP_SHL) || (op == OP_SHR);
  assign busy      = (state == ST_ITER);
  assign state_dbg = state;

  // The adder serves the ADD/SUB path when idle and the partial-product add while iterating.
  always_comb begin
    as_a   = a;
    as_b   = b;
    as_sub = (op == OP_SUB);
    if (state == ST_ITER) begin
      as_a   = acc;
      as_b   = mplier[0] ? mcand : '0;
      as_sub = 1'b0;
    end
  end

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (as_a),
    .b    (as_b),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  always_comb begin
    alu_res = a;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res = as_sum;
        alu_c   = as_cout;
        alu_o   = as_ovf;
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      default: alu_res = a;
    endcase
  end

  always_comb begin
    sh_step  = (op_r == OP_SHL) ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
    sh_out   = (op_r == OP_SHL) ? sh[WIDTH-1] : sh[0];
    acc_step = {as_cout, as_sum[WIDTH-1:1]};
    mpl_step = {as_sum[0], mplier[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_r   <= OP_ADD;
      count  <= '0;
      sh     <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      done   <= 1'b0;
      result <= '0;
      hi     <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_r   <= op;
            sh     <= a;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            if (op == OP_MUL) begin
              count <= CW'(WIDTH);
              state <= ST_ITER;
            end else if (is_shift && (shamt != '0)) begin
              count <= CW'(shamt);
              state <= ST_ITER;
            end else begin
              result <= alu_res;
              hi     <= '0;
              cout   <= alu_c;
              ovf    <= alu_o;
              zero   <= (alu_res == '0);
              neg    <= alu_res[WIDTH-1];
              done   <= 1'b1;
            end
          end
        end
        ST_ITER: begin
          count <= count - CW'(1);
          if (op_r == OP_MUL) begin
            acc    <= acc_step;
            mplier <= mpl_step;
          end else begin
            sh <= sh_step;
          end
          // Only the final step publishes; intermediate values stay internal.
          if (count == CW'(1)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            if (op_r == OP_MUL) begin
              result <= mpl_step;
              hi     <= acc_step;
              cout   <= 1'b0;
              ovf    <= |acc_step;
              zero   <= (mpl_step == '0);
              neg    <= mpl_step[WIDTH-1];
            end else begin
              result <= sh_step;
              hi     <= '0;
              cout   <= sh_out;
              ovf    <= 1'b0;
              zero   <= (sh_step == '0);
              neg    <= sh_step[WIDTH-1];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq with a queue-based scoreboard and done-edge monitor.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf, zero, neg;
  logic [W-1:0] result, hi;
  state_t       state_dbg;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic         c;
    logic         o;
    logic         z;
    logic         n;
    logic [31:0]  edge_no;
    logic [31:0]  nb;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;
  int busy_cnt = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .hi        (hi),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg),
    .state_dbg (state_dbg)
  );

  // Clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver: holds start for one edge starting #1 after a rising edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input int n, input logic push,
                       input logic [W-1:0] er, input logic [W-1:0] eh,
                       input logic ec, input logic eo, input logic ez, input logic en);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = ia;
    b     = ib;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.r       = er;
      e.h       = eh;
      e.c       = ec;
      e.o       = eo;
      e.z       = ez;
      e.n       = en;
      e.edge_no = cyc + n;
      e.nb      = n;
      exp_q.push_back(e);
    end
  endtask

  task automatic noise(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      start = 1'b1;
      op    = 3'($urandom_range(0, 7));
      a     = W'($urandom_range(0, 255));
      b     = W'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle_timeout: busy=1 after %0d cycles, expected 0", k);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: done=1 at edge %0d, expected no done", cyc);
        end else begin
          e_mon = exp_q.pop_front();
          check("result",      32'(result),   32'(e_mon.r));
          check("hi",          32'(hi),       32'(e_mon.h));
          check("cout",        32'(cout),     32'(e_mon.c));
          check("ovf",         32'(ovf),      32'(e_mon.o));
          check("zero",        32'(zero),     32'(e_mon.z));
          check("neg",         32'(neg),      32'(e_mon.n));
          check("done_edge",   32'(cyc),      e_mon.edge_no);
          check("busy_cycles", 32'(busy_cnt), e_mon.nb);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic check_cleared(input string tag);
    check({tag, "_result"}, 32'(result), 32'h0);
    check({tag, "_hi"},     32'(hi),     32'h0);
    check({tag, "_flags"},  32'({cout, ovf, zero, neg}), 32'h0);
    check({tag, "_busy"},   32'(busy),   32'h0);
    check({tag, "_done"},   32'(done),   32'h0);
    check({tag, "_state"},  32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    int k;
    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_cleared("reset");

    // Back-to-back single-cycle ops
    issue(OP_ADD, 8'h7F, 8'h01, 0, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(OP_SUB, 8'h00, 8'h01, 0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(OP_SUB, 8'h05, 8'h05, 0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(OP_ADD, 8'h80, 8'h80, 0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    issue(OP_OR,  8'hA0, 8'h05, 0, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(OP_XOR, 8'hFF, 8'h0F, 0, 1'b1, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(OP_SHL, 8'h01, 8'h08, 0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Iterative shifts
    issue(OP_SHL, 8'h81, 8'h01, 1, 1'b1, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    issue(OP_SHR, 8'h81, 8'h03, 3, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle();
    issue(OP_SHL, 8'h0F, 8'h07, 7, 1'b1, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Multiply with ignored starts, then a start in the done cycle
    issue(OP_MUL, 8'hFF, 8'hFF, 8, 1'b1, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);
    noise(3);
    wait_idle();
    issue(OP_ADD, 8'h12, 8'h34, 0, 1'b1, 8'h46, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(OP_MUL, 8'h0F, 8'h03, 8, 1'b1, 8'h2D, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle();
    issue(OP_MUL, 8'h00, 8'h37, 8, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_idle();

    // Abort a multiply with reset at its fourth iteration
    issue(OP_OR,  8'hA0, 8'h05, 0, 1'b1, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(OP_MUL, 8'h5A, 8'h5A, 8, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_cleared("abort");
    repeat (10) @(posedge clk);
    #1;
    issue(OP_AND, 8'hF0, 8'h3C, 0, 1'b1, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
